mmio_serial_port: RTL and testbench

MMIO_SERIAL_PORT -- requirements
Module: mmio_serial_port

---
 rtl/mmio_serial_port.sv | 120 ++++++++++++
 tb/tb_mmio_serial_port.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_serial_port.sv
// Memory-mapped serial port: TX/RX FIFOs between a register interface and a
// ready/valid character link, with loopback and sticky error flags.
module mmio_serial_port #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] serial_out,
    output logic              serial_wren_out,
    input  logic              serial_ready_in,
    input  logic [DATA_W-1:0] serial_in,
    input  logic              serial_valid_in,
    output logic              serial_rden_out
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_CW = RX_AW + 1;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_RXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
    logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
    logic [TX_CW-1:0]  tx_count;
    logic [RX_CW-1:0]  rx_count;
    logic              loopback, tx_overflow, rx_underflow;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_ovf_set, rx_udf_set, flag_clear, ctrl_wr;
    logic [DATA_W-1:0] tx_head, rx_head, rx_push_data;
    logic wdata_unused;

    assign wdata_unused = ^wdata[31:2];

    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign tx_head  = tx_mem[tx_rd_ptr];
    assign rx_head  = rx_mem[rx_rd_ptr];

    // Full/empty are judged on cycle-start counts, so a drain never rescues a full write.
    assign tx_push    = we && (addr == A_TXDATA) && !tx_full;
    assign tx_ovf_set = we && (addr == A_TXDATA) && tx_full;
    assign tx_pop     = !tx_empty && (loopback ? !rx_full : serial_ready_in);
    assign serial_rden_out = serial_valid_in && !rx_full && !loopback;
    assign rx_push      = serial_rden_out || (loopback && !tx_empty && !rx_full);
    assign rx_push_data = loopback ? tx_head : serial_in;
    assign rx_pop     = re && (addr == A_RXDATA) && !rx_empty;
    assign rx_udf_set = re && (addr == A_RXDATA) && rx_empty;
    assign ctrl_wr    = we && (addr == A_CTRL);
    assign flag_clear = ctrl_wr && wdata[1];

    // FIFO storage needs no reset; validity is tracked by the counts.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wdata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr       <= '0;
            tx_rd_ptr       <= '0;
            tx_count        <= '0;
            rx_wr_ptr       <= '0;
            rx_rd_ptr       <= '0;
            rx_count        <= '0;
            serial_out      <= '0;
            serial_wren_out <= 1'b0;
            loopback        <= 1'b0;
            tx_overflow     <= 1'b0;
            rx_underflow    <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CW'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - TX_CW'(1);

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CW'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CW'(1);

            serial_wren_out <= tx_pop && !loopback;
            if (tx_pop && !loopback) serial_out <= tx_head;

            if (ctrl_wr) loopback <= wdata[0];
            // A same-cycle set wins over the clear.
            tx_overflow  <= tx_ovf_set || (tx_overflow && !flag_clear);
            rx_underflow <= rx_udf_set || (rx_underflow && !flag_clear);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_RXDATA: rdata = rx_empty ? 32'd0 : 32'(rx_head);
            A_STATUS: rdata = {8'd0, 8'(rx_count), 8'(tx_count), 2'b00,
                               rx_underflow, tx_overflow,
                               rx_empty, rx_full, tx_empty, tx_full};
            A_CTRL:   rdata = {31'd0, loopback};
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_serial_port.sv
// Directed vector bench for mmio_serial_port at DATA_W=8, depths of 4.
module tb_mmio_serial_port;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        we, re;
    logic [31:0] rdata;
    logic [7:0]  serial_out;
    logic        serial_wren_out;
    logic        serial_ready_in;
    logic [7:0]  serial_in;
    logic        serial_valid_in;
    logic        serial_rden_out;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_serial_port #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .addr            (addr),
        .wdata           (wdata),
        .we              (we),
        .re              (re),
        .rdata           (rdata),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .serial_ready_in (serial_ready_in),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_rden_out (serial_rden_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic        rdy;
        logic        vld;
        logic [7:0]  sin;
        logic [31:0] e_rdata;
        logic        e_rden;
        logic        e_wren;
        logic [7:0]  e_sout;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [1:0] a, input logic w, input logic r,
                                input logic [31:0] wd, input logic rdy, input logic vld,
                                input logic [7:0] sin, input logic [31:0] erd,
                                input logic erden, input logic ewren, input logic [7:0] esout);
        vec_t v;
        v.addr = a; v.we = w; v.re = r; v.wdata = wd; v.rdy = rdy; v.vld = vld;
        v.sin = sin; v.e_rdata = erd; v.e_rden = erden; v.e_wren = ewren; v.e_sout = esout;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic w, input logic r, input logic [31:0] wd,
                         input logic rdy, input logic vld, input logic [7:0] sin);
        addr = a; we = w; re = r; wdata = wd;
        serial_ready_in = rdy; serial_valid_in = vld; serial_in = sin;
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled before
    // the rising edge, registered outputs just after it.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clock);
        drive(v.addr, v.we, v.re, v.wdata, v.rdy, v.vld, v.sin);
        #1;
        check($sformatf("v%0d rdata", idx), rdata, v.e_rdata);
        check($sformatf("v%0d rden", idx), 32'(serial_rden_out), 32'(v.e_rden));
        @(posedge clock);
        #1;
        check($sformatf("v%0d wren", idx), 32'(serial_wren_out), 32'(v.e_wren));
        check($sformatf("v%0d sout", idx), 32'(serial_out), 32'(v.e_sout));
    endtask

    task automatic idle_cycle(input logic [1:0] a, input logic rdy);
        @(negedge clock);
        drive(a, 1'b0, 1'b0, 32'd0, rdy, 1'b0, 8'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(2'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset status", rdata, 32'h0000000A);
        check("reset wren", 32'(serial_wren_out), 32'd0);
        check("reset sout", 32'(serial_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // addr we re wdata rdy vld sin | rdata rden wren sout
        // back-to-back TX: 0x48 then 0x69 strobe on consecutive edges
        vq.push_back(mk(0, 1, 0, 32'h48, 1, 0, 0, 32'h0,     0, 0, 8'h00));
        vq.push_back(mk(0, 1, 0, 32'h69, 1, 0, 0, 32'h0,     0, 1, 8'h48));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h108,   0, 1, 8'h69));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h69));
        // five writes into a stalled 4-deep TX FIFO; rx_empty contributes bit3
        for (int i = 1; i <= 5; i++)
            vq.push_back(mk(0, 1, 0, 32'(i), 0, 0, 0, 32'h0, 0, 0, 8'h69));
        vq.push_back(mk(2, 0, 0, 32'h0,  0, 0, 0, 32'h419,   0, 0, 8'h69));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h419,   0, 1, 8'h01));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h318,   0, 1, 8'h02));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h218,   0, 1, 8'h03));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h118,   0, 1, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h1A,    0, 0, 8'h04));
        vq.push_back(mk(3, 1, 0, 32'h2,  1, 0, 0, 32'h0,     0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h04));
        // RX receive, reads, underflow and its clear
        vq.push_back(mk(1, 0, 0, 32'h0,  1, 1, 8'h41, 32'h0,  1, 0, 8'h04));
        vq.push_back(mk(1, 0, 0, 32'h0,  1, 1, 8'h42, 32'h41, 1, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 0, 0, 32'h41,    0, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 0, 0, 32'h42,    0, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 0, 0, 32'h0,     0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h2A,    0, 0, 8'h04));
        vq.push_back(mk(3, 1, 0, 32'h2,  1, 0, 0, 32'h0,     0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h04));
        // loopback
        vq.push_back(mk(3, 1, 0, 32'h1,  1, 0, 0, 32'h0,     0, 0, 8'h04));
        vq.push_back(mk(0, 1, 0, 32'h55, 1, 0, 0, 32'h0,     0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h108,   0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h10002, 0, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 0, 0, 32'h55,    0, 0, 8'h04));
        vq.push_back(mk(3, 0, 0, 32'h0,  1, 1, 8'h77, 32'h1,  0, 0, 8'h04));
        vq.push_back(mk(3, 1, 0, 32'h0,  1, 0, 0, 32'h1,     0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h04));
        // fill RX, back-pressure, read frees a slot
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(2, 0, 0, 32'h0, 1, 1, 8'(8'h10 + i),
                            (i == 0) ? 32'hA : ((32'(i) << 16) | 32'h2), 1, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 1, 8'h14, 32'h40006, 0, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 1, 8'h14, 32'h10,    0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 1, 8'h14, 32'h30002, 1, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h40006,     0, 0, 8'h04));
        for (int i = 1; i <= 4; i++)
            vq.push_back(mk(1, 0, 1, 32'h0, 1, 0, 0, 32'(8'h10 + i), 0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h04));
        // writes to RXDATA/STATUS ignored
        vq.push_back(mk(2, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'hA, 0, 0, 8'h04));
        vq.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h04));
        // RX simultaneous push and pop
        vq.push_back(mk(1, 0, 0, 32'h0,  1, 1, 8'h21, 32'h0,  1, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 1, 8'h22, 32'h21, 1, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h10002, 0, 0, 8'h04));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 0, 0, 32'h22,    0, 0, 8'h04));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'h04));
        // write while full is dropped even with a same-cycle drain
        for (int i = 1; i <= 4; i++)
            vq.push_back(mk(0, 1, 0, 32'(8'hA0 + i), 0, 0, 0, 32'h0, 0, 0, 8'h04));
        vq.push_back(mk(0, 1, 0, 32'hA5, 1, 0, 0, 32'h0,     0, 1, 8'hA1));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h318,   0, 1, 8'hA2));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h218,   0, 1, 8'hA3));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h118,   0, 1, 8'hA4));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h1A,    0, 0, 8'hA4));
        vq.push_back(mk(3, 1, 0, 32'h2,  1, 0, 0, 32'h0,     0, 0, 8'hA4));
        // read while empty with a same-cycle push still underflows
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 1, 8'h31, 32'h0,  1, 0, 8'hA4));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'h10022, 0, 0, 8'hA4));
        vq.push_back(mk(1, 0, 1, 32'h0,  1, 0, 0, 32'h31,    0, 0, 8'hA4));
        vq.push_back(mk(3, 1, 0, 32'h2,  1, 0, 0, 32'h0,     0, 0, 8'hA4));
        vq.push_back(mk(2, 0, 0, 32'h0,  1, 0, 0, 32'hA,     0, 0, 8'hA4));

        foreach (vq[i]) apply(i, vq[i]);

        // Reset mid-drain: four queued, one strobed, three in flight.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            drive(2'd0, 1'b1, 1'b0, 32'(8'hB0 + i), 1'b0, 1'b0, 8'd0);
        end
        idle_cycle(2'd2, 1'b1);
        check("drain strobe", 32'(serial_wren_out), 32'd1);
        check("drain sout", 32'(serial_out), 32'hB1);
        check("drain status", rdata, 32'h00000308);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async wren", 32'(serial_wren_out), 32'd0);
        check("async sout", 32'(serial_out), 32'd0);
        check("async status", rdata, 32'h0000000A);
        @(posedge clock);
        #1;
        check("held wren", 32'(serial_wren_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle_cycle(2'd2, 1'b1);
        check("post-reset wren", 32'(serial_wren_out), 32'd0);
        check("post-reset status", rdata, 32'h0000000A);

        // Resume from empty: one-edge latency from write to strobe.
        @(negedge clock);
        drive(2'd0, 1'b1, 1'b0, 32'hC3, 1'b1, 1'b0, 8'd0);
        @(posedge clock);
        #1;
        check("resume no strobe", 32'(serial_wren_out), 32'd0);
        idle_cycle(2'd2, 1'b1);
        check("resume strobe", 32'(serial_wren_out), 32'd1);
        check("resume sout", 32'(serial_out), 32'hC3);
        idle_cycle(2'd2, 1'b1);
        check("resume idle", 32'(serial_wren_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
